// File: rtl/m_ext_pkg.sv
// Shared RV32M constants: funct3 operation codes and sequencer state encoding.
package m_ext_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/m_ext_seq_unit_if.sv
// Request/response bundle between the execute stage and the M-extension unit.
interface m_ext_seq_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            ip_start;
    logic [2:0]      ip_funct_3;
    logic [XLEN-1:0] ip_operand_a;
    logic [XLEN-1:0] ip_operand_b;
    logic            ip_flush;
    logic            op_busy;
    logic            op_done;
    logic [XLEN-1:0] op_result;

    modport master (
        output ip_start, ip_funct_3, ip_operand_a, ip_operand_b, ip_flush,
        input  op_busy, op_done, op_result
    );

    modport slave (
        input  ip_start, ip_funct_3, ip_operand_a, ip_operand_b, ip_flush,
        output op_busy, op_done, op_result
    );
endinterface

// File: rtl/m_ext_iter_core.sv
// Iterative engine: shift-add multiply and restoring divide over one shared accumulator.
module m_ext_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc,
    output logic              cnt_zero_c
);
    localparam int unsigned CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   opr_q;
    logic [CW-1:0]     cnt_q;
    logic              div_q;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_part;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;

    // One iteration: multiply adds into the high half then shifts right;
    // divide shifts left, trial-subtracts and shifts in the quotient bit.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opr_q} : '0);
        div_part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge   = (div_part >= {1'b0, opr_q});
        div_diff = div_part[XLEN-1:0] - opr_q;
        if (div_q) begin
            acc_d = {(div_ge ? div_diff : div_part[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Load operands (multiplier / dividend in the low half) or advance one step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            opr_q <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            acc_q <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            opr_q <= is_div ? b_mag : a_mag;
            cnt_q <= CW'(XLEN - 1);
            div_q <= is_div;
        end else if (step) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign acc        = acc_q;
    assign cnt_zero_c = (cnt_q == '0);

endmodule

// File: rtl/m_ext_seq_unit.sv
// Sequential RV32M execute unit: FSM, operand conditioning, fast paths and sign fix-up.
module m_ext_seq_unit
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_FAST = 0
) (
    input  logic             ip_clk,
    input  logic             ip_rst_n,
    m_ext_seq_unit_if.slave  bus
);
    localparam int unsigned     W2      = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic              accept_c, step_c, load_c, fast_c;
    logic              is_div_c, a_neg_c, b_neg_c, neg_c, b_zero_c, ovf_c;
    logic [XLEN-1:0]   a_mag_c, b_mag_c, fast_res_c, fin_res_c;
    logic [2:0]        op_q;
    logic              neg_q, fast_q;
    logic [XLEN-1:0]   fast_res_q;
    logic [W2-1:0]     acc;
    logic              cnt_zero_c;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q;

    // Apply the result sign and pick the half that the operation returns.
    function automatic logic [XLEN-1:0] sel_result(input logic [2:0] op, input logic neg,
                                                   input logic [W2-1:0] val);
        logic [W2-1:0]   prod;
        logic [XLEN-1:0] q, r, res;
        prod = neg ? -val : val;
        q    = val[XLEN-1:0];
        r    = val[W2-1:XLEN];
        case (op)
            MUL:                 res = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: res = prod[W2-1:XLEN];
            DIV, DIVU:           res = neg ? -q : q;
            default:             res = neg ? -r : r;
        endcase
        return res;
    endfunction

    assign is_div_c = bus.ip_funct_3[2];
    assign a_neg_c  = (bus.ip_funct_3 inside {MULH, MULHSU, DIV, REM}) & bus.ip_operand_a[XLEN-1];
    assign b_neg_c  = (bus.ip_funct_3 inside {MULH, DIV, REM}) & bus.ip_operand_b[XLEN-1];
    assign a_mag_c  = a_neg_c ? -bus.ip_operand_a : bus.ip_operand_a;
    assign b_mag_c  = b_neg_c ? -bus.ip_operand_b : bus.ip_operand_b;
    // Remainders follow the dividend; quotients and products follow the operand signs.
    assign neg_c    = (is_div_c & bus.ip_funct_3[1]) ? a_neg_c : (a_neg_c ^ b_neg_c);
    assign b_zero_c = (bus.ip_operand_b == '0);
    assign ovf_c    = (bus.ip_funct_3 inside {DIV, REM}) && (bus.ip_operand_a == MIN_NEG)
                      && (bus.ip_operand_b == '1);
    assign fast_c   = is_div_c ? (b_zero_c | ovf_c) : (MUL_FAST != 0);
    assign load_c   = accept_c & ~fast_c;

    // Results that need no iteration: divide-by-zero, signed overflow, native multiply.
    always_comb begin
        fast_res_c = '0;
        if (is_div_c && b_zero_c) begin
            fast_res_c = bus.ip_funct_3[1] ? bus.ip_operand_a : '1;
        end else if (is_div_c) begin
            fast_res_c = bus.ip_funct_3[1] ? '0 : bus.ip_operand_a;
        end else if (MUL_FAST != 0) begin
            fast_res_c = sel_result(bus.ip_funct_3, neg_c, W2'(a_mag_c) * W2'(b_mag_c));
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ip_start && !bus.ip_flush) begin
                    accept_c = 1'b1;
                    state_d  = fast_c ? FIN : RUN;
                end
            end
            RUN: begin
                step_c = ~bus.ip_flush;
                if (cnt_zero_c) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.ip_flush) begin
            state_d = IDLE;
        end
    end

    assign fin_res_c = fast_q ? fast_res_q : sel_result(op_q, neg_q, acc);

    // State register.
    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture op code, sign and any fast-path result at accept.
    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            op_q       <= MUL;
            neg_q      <= 1'b0;
            fast_q     <= 1'b0;
            fast_res_q <= '0;
        end else if (accept_c) begin
            op_q       <= bus.ip_funct_3;
            neg_q      <= neg_c;
            fast_q     <= fast_c;
            fast_res_q <= fast_res_c;
        end
    end

    // Registered outputs: busy decodes the next state, done/result load on leaving FIN.
    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_q == FIN) && !bus.ip_flush;
            if ((state_q == FIN) && !bus.ip_flush) begin
                result_q <= fin_res_c;
            end
        end
    end

    m_ext_iter_core #(.XLEN(XLEN)) u_core (
        .clk        (ip_clk),
        .rst_n      (ip_rst_n),
        .load       (load_c),
        .step       (step_c),
        .is_div     (is_div_c),
        .a_mag      (a_mag_c),
        .b_mag      (b_mag_c),
        .acc        (acc),
        .cnt_zero_c (cnt_zero_c)
    );

    assign bus.op_busy   = busy_q;
    assign bus.op_done   = done_q;
    assign bus.op_result = result_q;

endmodule

// File: tb/tb_m_ext_seq_unit.sv
// Bench: iterative unit (index 0) and fast-multiply unit (index 1) against an arithmetic model.
module tb_m_ext_seq_unit;
    import m_ext_pkg::*;

    localparam int ITER_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        chk_en;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        start_s [2];
    logic [2:0]  funct_s [2];
    logic [31:0] a_s     [2];
    logic [31:0] b_s     [2];
    logic        flush_s [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [31:0] result_w[2];

    int          m_left  [2];
    logic        m_busy  [2];
    logic        m_done  [2];
    logic [31:0] m_result[2];
    logic [31:0] m_pend  [2];

    always #5 clk = ~clk;

    m_ext_seq_unit_if #(.XLEN(32)) bus0 ();
    m_ext_seq_unit_if #(.XLEN(32)) bus1 ();

    assign bus0.ip_start     = start_s[0];
    assign bus0.ip_funct_3   = funct_s[0];
    assign bus0.ip_operand_a = a_s[0];
    assign bus0.ip_operand_b = b_s[0];
    assign bus0.ip_flush     = flush_s[0];
    assign busy_w[0]         = bus0.op_busy;
    assign done_w[0]         = bus0.op_done;
    assign result_w[0]       = bus0.op_result;
    assign bus1.ip_start     = start_s[1];
    assign bus1.ip_funct_3   = funct_s[1];
    assign bus1.ip_operand_a = a_s[1];
    assign bus1.ip_operand_b = b_s[1];
    assign bus1.ip_flush     = flush_s[1];
    assign busy_w[1]         = bus1.op_busy;
    assign done_w[1]         = bus1.op_done;
    assign result_w[1]       = bus1.op_result;

    m_ext_seq_unit #(.XLEN(32), .MUL_FAST(0)) u_dut0 (.ip_clk(clk), .ip_rst_n(rst_n), .bus(bus0));
    m_ext_seq_unit #(.XLEN(32), .MUL_FAST(1)) u_dut1 (.ip_clk(clk), .ip_rst_n(rst_n), .bus(bus1));

    // RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        t  = '0;
        case (op)
            MUL:    t = {32'b0, a} * {32'b0, b};
            MULH:   t = 64'(sa * sb);
            MULHSU: t = 64'(sa * ub);
            MULHU:  t = {32'b0, a} * {32'b0, b};
            DIV:    t = 64'((b == 0) ? -1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb);
            REM:    t = 64'((b == 0) ? sa : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb);
            DIVU:   t = (b == 0) ? 64'hFFFF_FFFF : {32'b0, a} / {32'b0, b};
            default: t = (b == 0) ? {32'b0, a} : {32'b0, a} % {32'b0, b};
        endcase
        if (op inside {MULH, MULHSU, MULHU}) return t[63:32];
        return t[31:0];
    endfunction

    function automatic int latency(input int k, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && (b == 0 || ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        if (!op[2] && k == 1) return 1;
        return ITER_LAT;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted op completes a fixed number of edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_left[k] <= 0; m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_result[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] <= 1'b0;
                if (flush_s[k]) begin
                    m_left[k] <= 0;
                    m_busy[k] <= 1'b0;
                end else if (m_left[k] > 0) begin
                    m_left[k] <= m_left[k] - 1;
                    if (m_left[k] == 1) begin
                        m_done[k] <= 1'b1; m_result[k] <= m_pend[k]; m_busy[k] <= 1'b0;
                    end
                end else if (start_s[k]) begin
                    m_pend[k] <= ref_result(funct_s[k], a_s[k], b_s[k]);
                    m_left[k] <= latency(k, funct_s[k], a_s[k], b_s[k]);
                    m_busy[k] <= 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both units against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d busy", k), 32'(busy_w[k]), 32'(m_busy[k]));
                check($sformatf("u%0d done", k), 32'(done_w[k]), 32'(m_done[k]));
                check($sformatf("u%0d result", k), result_w[k], m_result[k]);
            end
        end
    end

    // Issue one op at a negedge with the unit idle; optionally inject a stray start or a flush.
    task automatic run_op(input int k, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int inject_at,
                          input int flush_at, input string tag);
        int          e, busy_cyc;
        logic [31:0] prev;
        bit          any_done, changed;
        prev = result_w[k];
        start_s[k] = 1'b1; funct_s[k] = op; a_s[k] = a; b_s[k] = b;
        @(negedge clk);
        start_s[k] = 1'b0; funct_s[k] = 3'($urandom); a_s[k] = $urandom; b_s[k] = $urandom;
        e = 0; busy_cyc = 0;
        while (1) begin
            if (e == flush_at) begin
                flush_s[k] = 1'b1;
                @(negedge clk);
                flush_s[k] = 1'b0;
                check({tag, " flush busy"}, 32'(busy_w[k]), 32'd0);
                any_done = 0; changed = 0;
                for (int i = 0; i < 40; i++) begin
                    if (done_w[k]) any_done = 1;
                    if (result_w[k] !== prev) changed = 1;
                    @(negedge clk);
                end
                check({tag, " flush no done"}, 32'(any_done), 32'd0);
                check({tag, " flush result kept"}, 32'(changed), 32'd0);
                return;
            end
            if (done_w[k] || e > 100) break;
            if (busy_w[k]) busy_cyc++;
            if (e == inject_at) begin
                start_s[k] = 1'b1; funct_s[k] = 3'($urandom); a_s[k] = $urandom; b_s[k] = $urandom;
            end
            @(negedge clk);
            start_s[k] = 1'b0;
            e++;
        end
        check({tag, " latency"}, 32'(e), 32'(lat));
        check({tag, " busy cycles"}, 32'(busy_cyc), 32'(lat));
        check({tag, " result"}, result_w[k], exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          k, lat, fl, inj;
        rst_n = 1'b0; chk_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; funct_s[i] = '0; a_s[i] = '0; b_s[i] = '0; flush_s[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy_w[0]), 32'd0);
        check("reset done", 32'(done_w[0]), 32'd0);
        check("reset result", result_w[0], 32'd0);
        rst_n = 1'b1; chk_en = 1'b1;
        @(negedge clk);

        check("pin mulhsu", ref_result(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("pin rem", ref_result(REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("pin divovf", ref_result(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        run_op(0, MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, ITER_LAT, -1, -1, "mul 7*-3");
        run_op(0, MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, ITER_LAT, -1, -1, "mulh min*min");
        run_op(0, MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, ITER_LAT, -1, -1, "mulhu");
        run_op(0, MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, ITER_LAT, -1, -1, "mulhsu");
        run_op(0, DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, ITER_LAT, -1, -1, "div -7/2");
        run_op(0, REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, ITER_LAT, -1, -1, "rem -7/2");
        run_op(0, DIVU,   32'd100,        32'd7,         32'd14,        ITER_LAT, -1, -1, "divu 100/7");
        run_op(0, REMU,   32'd100,        32'd7,         32'd2,         ITER_LAT, -1, -1, "remu 100/7");
        run_op(0, DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1, -1, -1, "div by 0");
        run_op(0, REMU,   32'd5,          32'd0,         32'd5,         1, -1, -1, "remu by 0");
        run_op(0, DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, -1, -1, "div ovf");
        run_op(0, REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, -1, -1, "rem ovf");
        run_op(0, DIVU,   32'd100,        32'd7,         32'd14,        ITER_LAT, 5, -1, "ignored start");
        run_op(0, DIV,    32'd1000,       32'd3,         32'd333,       ITER_LAT, -1, 9, "flush run10");

        // Flush and start in the same cycle: the start must be dropped.
        start_s[0] = 1'b1; flush_s[0] = 1'b1; funct_s[0] = DIVU; a_s[0] = 32'd9; b_s[0] = 32'd2;
        @(negedge clk);
        start_s[0] = 1'b0; flush_s[0] = 1'b0;
        check("flush+start busy", 32'(busy_w[0]), 32'd0);
        repeat (3) @(negedge clk);

        // Back-to-back: second start issued in the done cycle of the first.
        run_op(0, MULHU, 32'd3, 32'd5, 32'd0, ITER_LAT, -1, -1, "b2b first");
        check("b2b done cycle", 32'(done_w[0]), 32'd1);
        run_op(0, DIVU, 32'd77, 32'd10, 32'd7, ITER_LAT, -1, -1, "b2b second");

        run_op(1, MUL,   32'd3,         32'd4,         32'd12,        1, -1, -1, "fast mul 3*4");
        run_op(1, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, -1, -1, "fast mulhu");

        // Reset in the middle of an iterative op clears every output immediately.
        start_s[0] = 1'b1; funct_s[0] = DIV; a_s[0] = 32'd12345; b_s[0] = 32'd7;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun reset busy", 32'(busy_w[0]), 32'd0);
        check("midrun reset done", 32'(done_w[0]), 32'd0);
        check("midrun reset result", result_w[0], 32'd0);
        check("midrun reset u1 result", result_w[1], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            k   = ($urandom % 3 == 0) ? 1 : 0;
            op  = 3'($urandom);
            a   = pick();
            b   = pick();
            lat = latency(k, op, a, b);
            fl  = ($urandom % 12 == 0) ? int'($urandom_range(0, lat - 1)) : -1;
            inj = ($urandom % 8 == 0 && lat > 2) ? int'($urandom_range(0, lat - 2)) : -1;
            run_op(k, op, a, b, ref_result(op, a, b), lat, inj, fl, $sformatf("rand%0d", i));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
